// File: rtl/seg_pkg.sv
// Seven-segment pattern constants, digit codes and the pattern-to-digit decode
// shared by the scan receiver and the display encoder.
package seg_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } slot_st_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam digit_t DIG_BLANK = 4'd11;
  localparam digit_t DIG_BAD   = 4'd15;

  function automatic digit_t seg_decode(input logic [6:0] seg);
    digit_t d;
    case (seg)
      SEG_0:     d = 4'd0;
      SEG_1:     d = 4'd1;
      SEG_2:     d = 4'd2;
      SEG_3:     d = 4'd3;
      SEG_4:     d = 4'd4;
      SEG_5:     d = 4'd5;
      SEG_6:     d = 4'd6;
      SEG_7:     d = 4'd7;
      SEG_8:     d = 4'd8;
      SEG_9:     d = 4'd9;
      SEG_BLANK: d = DIG_BLANK;
      default:   d = DIG_BAD;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg_decode7.sv
// Combinational split of a {dp,g,f,e,d,c,b,a} segment pattern into the
// decimal-point bit and a 4-bit digit code.
module seg_decode7
  import seg_pkg::*;
(
  input  logic [7:0] pat,
  output logic       dp,
  output digit_t     code
);

  assign dp   = pat[7];
  assign code = seg_decode(pat[6:0]);

endmodule

// File: rtl/seg_scan_rx.sv
// Multiplexed 4-digit seven-segment receiver: settles each slot, decodes it and
// publishes whole frames. Optional change flag under SEG_SCAN_RX_CHG_DET_EN.
//
// state     | meaning
// ST_IDLE   | enables not one-hot, nothing to sample
// ST_SETTLE | one-hot enable, counting identical samples
// ST_HOLD   | slot captured, waiting for the enable to move
module seg_scan_rx
  import seg_pkg::*;
#(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 2000000,
  parameter logic        ENA_ACT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ena,
  input  logic [7:0] light,
  output digit_t     d0,
  output digit_t     d1,
  output digit_t     d2,
  output digit_t     d3,
  output logic [3:0] dp,
  output logic       frame_vld,
  output logic       scan_err,
  output logic       bad_seg
`ifdef SEG_SCAN_RX_CHG_DET_EN
  ,
  output logic       chg
`endif
);

  localparam int unsigned TW       = $clog2(TIMEOUT + 1);
  localparam logic [3:0]  SET_LAST = 4'(SETTLE - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  logic [3:0]    ena_q, ena_p;
  logic [7:0]    light_q, light_p;
  slot_st_t      state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic [3:0]    mask;
  digit_t        sh_code [4];
  logic [3:0]    sh_dp;
  logic [TW-1:0] tmo;

  logic   onehot, ena_chg, same, cap, commit;
  logic   dec_dp;
  digit_t dec_code;

  seg_decode7 u_dec (
    .pat  (light_q),
    .dp   (dec_dp),
    .code (dec_code)
  );

  assign onehot  = (ena_q != 4'd0) && ((ena_q & (ena_q - 4'd1)) == 4'd0);
  assign ena_chg = (ena_q != ena_p);
  assign same    = !ena_chg && (light_q == light_p);
  assign commit  = (mask == 4'hF);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cap      = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nx = 4'd0;
        if (onehot) state_nx = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!onehot) begin
          state_nx = ST_IDLE;
          cnt_nx   = 4'd0;
        end else if (same) begin
          cnt_nx = cnt + 4'd1;
        end else begin
          cnt_nx = 4'd0;
        end
      end
      ST_HOLD: begin
        if (ena_chg) begin
          cnt_nx   = 4'd0;
          state_nx = onehot ? ST_SETTLE : ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
    // The sample entering SETTLE counts as the first of SETTLE equal samples.
    if (state_nx == ST_SETTLE && cnt_nx == SET_LAST) begin
      cap      = 1'b1;
      state_nx = ST_HOLD;
      cnt_nx   = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ena_q     <= 4'd0;
      ena_p     <= 4'd0;
      light_q   <= 8'd0;
      light_p   <= 8'd0;
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      mask      <= 4'd0;
      sh_dp     <= 4'd0;
      for (int k = 0; k < 4; k++) sh_code[k] <= DIG_BLANK;
      tmo       <= '0;
      d0        <= DIG_BLANK;
      d1        <= DIG_BLANK;
      d2        <= DIG_BLANK;
      d3        <= DIG_BLANK;
      dp        <= 4'd0;
      frame_vld <= 1'b0;
      scan_err  <= 1'b0;
      bad_seg   <= 1'b0;
    end else begin
      ena_q   <= ENA_ACT ? ena : ~ena;
      light_q <= light;
      ena_p   <= ena_q;
      light_p <= light_q;
      state   <= state_nx;
      cnt     <= cnt_nx;

      if (cap) begin
        for (int k = 0; k < 4; k++) begin
          if (ena_q[k]) begin
            sh_code[k] <= dec_code;
            sh_dp[k]   <= dec_dp;
          end
        end
        if (dec_code == DIG_BAD) bad_seg <= 1'b1;
      end

      frame_vld <= 1'b0;
      if (commit) begin
        d0        <= sh_code[0];
        d1        <= sh_code[1];
        d2        <= sh_code[2];
        d3        <= sh_code[3];
        dp        <= sh_dp;
        frame_vld <= 1'b1;
        mask      <= cap ? ena_q : 4'd0;
      end else if (cap) begin
        mask <= mask | ena_q;
      end

      if (cap) tmo <= '0;
      else if (tmo != TMO_MAX) tmo <= tmo + TW'(1);
      scan_err <= !cap && (tmo == TMO_MAX);
    end
  end

`ifdef SEG_SCAN_RX_CHG_DET_EN
  logic have_frame;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg        <= 1'b0;
      have_frame <= 1'b0;
    end else begin
      chg <= 1'b0;
      if (commit) begin
        chg <= !have_frame ||
               ({sh_code[3], sh_code[2], sh_code[1], sh_code[0], sh_dp} != {d3, d2, d1, d0, dp});
        have_frame <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_seg_scan_rx.sv
// Directed bench for seg_scan_rx: timeout, frame decode, glitch rejection,
// multi-enable idle, sticky bad pattern and (optionally) change detection.
module tb_seg_scan_rx;
  import seg_pkg::*;

  localparam int TMO = 60;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ena = 4'd0;
  logic [7:0] light = 8'd0;
  digit_t     d0, d1, d2, d3;
  logic [3:0] dp;
  logic       frame_vld, scan_err, bad_seg;
`ifdef SEG_SCAN_RX_CHG_DET_EN
  logic       chg;
  logic       last_chg = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  int nfr = 0;

  seg_scan_rx #(.SETTLE(4), .TIMEOUT(TMO), .ENA_ACT(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .light     (light),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .dp        (dp),
    .frame_vld (frame_vld),
    .scan_err  (scan_err),
    .bad_seg   (bad_seg)
`ifdef SEG_SCAN_RX_CHG_DET_EN
    ,
    .chg       (chg)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_vld) begin
      nfr++;
`ifdef SEG_SCAN_RX_CHG_DET_EN
      last_chg = chg;
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] p0, p1, p2, p3, output bit got);
    logic [7:0] pats [4];
    int n0;
    n0 = nfr;
    pats = '{p0, p1, p2, p3};
    for (int k = 0; k < 4; k++) begin
      ena = 4'(1 << k);
      light = pats[k];
      step(8);
    end
    ena = 4'd0;
    light = 8'd0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(1);
      if (nfr != n0) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    #12;
    vectors++; if (d0 !== DIG_BLANK) begin miscompares++; $display("FAIL reset_d0 got %0d exp 11", d0); end
    vectors++; if (d3 !== DIG_BLANK) begin miscompares++; $display("FAIL reset_d3 got %0d exp 11", d3); end
    vectors++; if ({frame_vld, scan_err, bad_seg, dp} !== 7'd0) begin miscompares++; $display("FAIL reset_flags got %b exp 0", {frame_vld, scan_err, bad_seg, dp}); end
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic test_timeout();
    int n0;
    n0 = nfr;
    step(TMO);
    vectors++; if (scan_err !== 1'b0) begin miscompares++; $display("FAIL tmo_early got %b exp 0", scan_err); end
    step(1);
    vectors++; if (scan_err !== 1'b1) begin miscompares++; $display("FAIL tmo_rise got %b exp 1", scan_err); end
    vectors++; if ({d3, d2, d1, d0} !== 16'hBBBB) begin miscompares++; $display("FAIL tmo_digits got %h exp bbbb", {d3, d2, d1, d0}); end
    vectors++; if (nfr !== n0) begin miscompares++; $display("FAIL tmo_no_frame got %0d exp %0d", nfr, n0); end
  endtask

  task automatic test_frame();
    bit got;
    int n0;
    n0 = nfr;
    send_frame(8'h6F, 8'h6F, 8'h3F, 8'h00, got);
    step(5);
    vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL frame_seen got %b exp 1", got); end
    vectors++; if (nfr - n0 !== 1) begin miscompares++; $display("FAIL frame_count got %0d exp 1", nfr - n0); end
    vectors++; if ({d3, d2, d1, d0} !== 16'hB099) begin miscompares++; $display("FAIL frame_digits got %h exp b099", {d3, d2, d1, d0}); end
    vectors++; if (dp !== 4'd0) begin miscompares++; $display("FAIL frame_dp got %b exp 0000", dp); end
    vectors++; if (scan_err !== 1'b0) begin miscompares++; $display("FAIL frame_err_clr got %b exp 0", scan_err); end
  endtask

  task automatic test_glitch();
    bit got;
    int n0;
    n0 = nfr;
    ena = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      light = (i % 2 == 0) ? 8'h5B : 8'h06;
      step(2);
    end
    vectors++; if (dut.mask !== 4'b0000) begin miscompares++; $display("FAIL glitch_nocap got %b exp 0000", dut.mask); end
    light = 8'h5B;
    step(4);
    light = 8'h06;
    step(4);
    vectors++; if (dut.mask !== 4'b0001) begin miscompares++; $display("FAIL glitch_cap got %b exp 0001", dut.mask); end
    ena = 4'b0010; light = 8'h06; step(8);
    ena = 4'b0100; light = 8'h4F; step(8);
    ena = 4'b1000; light = 8'h66; step(8);
    ena = 4'd0; light = 8'd0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(1);
      if (nfr != n0) got = 1'b1;
    end
    vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL glitch_frame got %b exp 1", got); end
    vectors++; if ({d3, d2, d1, d0} !== 16'h4312) begin miscompares++; $display("FAIL glitch_digits got %h exp 4312", {d3, d2, d1, d0}); end
  endtask

  task automatic test_dual_ena();
    int n0;
    ena = 4'b0001; light = 8'h7F; step(8);
    n0 = nfr;
    ena = 4'b0011; step(20);
    ena = 4'b0000; step(3);
    vectors++; if (dut.state !== ST_IDLE) begin miscompares++; $display("FAIL dual_state got %0d exp 0", dut.state); end
    vectors++; if (dut.mask !== 4'b0001) begin miscompares++; $display("FAIL dual_mask got %b exp 0001", dut.mask); end
    vectors++; if (nfr !== n0) begin miscompares++; $display("FAIL dual_no_frame got %0d exp %0d", nfr, n0); end
  endtask

  task automatic test_bad_seg();
    bit got;
    send_frame(8'h3F, 8'h06, 8'h49, 8'h4F, got);
    vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL bad_frame got %b exp 1", got); end
    vectors++; if ({d3, d2, d1, d0} !== 16'h3F10) begin miscompares++; $display("FAIL bad_digits got %h exp 3f10", {d3, d2, d1, d0}); end
    vectors++; if (bad_seg !== 1'b1) begin miscompares++; $display("FAIL bad_set got %b exp 1", bad_seg); end
    send_frame(8'hFF, 8'h6F, 8'h07, 8'h7D, got);
    vectors++; if ({d3, d2, d1, d0} !== 16'h6798) begin miscompares++; $display("FAIL bad_next_digits got %h exp 6798", {d3, d2, d1, d0}); end
    vectors++; if (dp !== 4'b0001) begin miscompares++; $display("FAIL bad_next_dp got %b exp 0001", dp); end
    vectors++; if (bad_seg !== 1'b1) begin miscompares++; $display("FAIL bad_sticky got %b exp 1", bad_seg); end
    rst = 1'b1;
    #1;
    vectors++; if (bad_seg !== 1'b0) begin miscompares++; $display("FAIL bad_rst got %b exp 0", bad_seg); end
    vectors++; if ({d3, d2, d1, d0, dp} !== 20'hBBBB0) begin miscompares++; $display("FAIL rst_outputs got %h exp bbbb0", {d3, d2, d1, d0, dp}); end
    step(1);
    rst = 1'b0;
    step(1);
  endtask

`ifdef SEG_SCAN_RX_CHG_DET_EN
  task automatic test_chg();
    bit got;
    send_frame(8'h6F, 8'h6F, 8'h3F, 8'h00, got);
    vectors++; if ({got, last_chg} !== 2'b11) begin miscompares++; $display("FAIL chg_first got %b exp 11", {got, last_chg}); end
    send_frame(8'h6F, 8'h6F, 8'h3F, 8'h00, got);
    vectors++; if ({got, last_chg} !== 2'b10) begin miscompares++; $display("FAIL chg_same got %b exp 10", {got, last_chg}); end
    send_frame(8'h7F, 8'h6F, 8'h3F, 8'h00, got);
    vectors++; if ({got, last_chg} !== 2'b11) begin miscompares++; $display("FAIL chg_diff got %b exp 11", {got, last_chg}); end
    vectors++; if ({d3, d2, d1, d0} !== 16'hB098) begin miscompares++; $display("FAIL chg_digits got %h exp b098", {d3, d2, d1, d0}); end
  endtask
`endif

  initial begin
    test_reset();
    test_timeout();
    test_frame();
    test_glitch();
    test_dual_ena();
    test_bad_seg();
`ifdef SEG_SCAN_RX_CHG_DET_EN
    test_chg();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
